// File: rtl/shared_memory_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shared_memory_rr: banked scratchpad with one round-robin arbiter per bank.  |
// | Optional feature: define SHMEM_READ_BCAST_EN to merge same-word reads.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module shared_memory_rr #(
    parameter int N_CORES = 16,
    parameter int N_BANKS = 16,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        read,
    input  logic [N_CORES-1:0]        write,
    input  logic [N_CORES*ADDR_W-1:0] addr_in,
    input  logic [N_CORES*DATA_W-1:0] data_in,
    output logic [N_CORES*DATA_W-1:0] data_out,
    output logic [N_CORES-1:0]        finish
);
    localparam int BANK_W = $clog2(N_BANKS);
    localparam int WORD_W = ADDR_W - BANK_W;
    localparam int DEPTH  = 2**WORD_W;
    localparam int CORE_W = $clog2(N_CORES);
    localparam logic [CORE_W-1:0] PTR_RST = CORE_W'(N_CORES - 1);

    logic [BANK_W-1:0]  bank_sel [N_CORES];
    logic [WORD_W-1:0]  word_sel [N_CORES];
    logic [DATA_W-1:0]  wdata    [N_CORES];
    logic [N_CORES-1:0] req;

    logic [CORE_W-1:0]  ptr      [N_BANKS];
    logic [CORE_W-1:0]  gnt_idx  [N_BANKS];
    logic [N_BANKS-1:0] gnt_vld;
    logic [N_CORES-1:0] serve;

    logic [DATA_W-1:0]  mem [N_BANKS][DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_core
            assign bank_sel[gi] = addr_in[gi*ADDR_W +: BANK_W];
            assign word_sel[gi] = addr_in[gi*ADDR_W+BANK_W +: WORD_W];
            assign wdata[gi]    = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A core that is still showing finish is masked so the held request is not re-served.
    assign req = (read | write) & ~finish;

    always_comb begin
        int                cand;
        logic              found;
        logic [CORE_W-1:0] sel;
        logic [CORE_W-1:0] cidx;
        cand  = 0;
        found = 1'b0;
        sel   = '0;
        cidx  = '0;
        serve = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            found = 1'b0;
            sel   = '0;
            for (int k = 1; k <= N_CORES; k++) begin
                cand = int'(ptr[b]) + k;
                if (cand >= N_CORES) begin
                    cand = cand - N_CORES;
                end
                cidx = cand[CORE_W-1:0];
                if (!found && req[cidx] && (bank_sel[cidx] == BANK_W'(b))) begin
                    found = 1'b1;
                    sel   = cidx;
                end
            end
            gnt_vld[b] = found;
            gnt_idx[b] = sel;
            if (found) begin
                serve[sel] = 1'b1;
`ifdef SHMEM_READ_BCAST_EN
                // A read winner drags along every other reader of the very same word.
                if (!write[sel]) begin
                    for (int c = 0; c < N_CORES; c++) begin
                        if (req[c] && !write[c] && (bank_sel[c] == BANK_W'(b)) &&
                            (word_sel[c] == word_sel[sel])) begin
                            serve[c] = 1'b1;
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            finish   <= '0;
            data_out <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                ptr[b] <= PTR_RST;
            end
        end else begin
            finish <= serve;
            for (int b = 0; b < N_BANKS; b++) begin
                if (gnt_vld[b]) begin
                    ptr[b] <= gnt_idx[b];
                end
            end
            // Read-first: the RAM read below sees the value before any same-edge write.
            for (int c = 0; c < N_CORES; c++) begin
                if (serve[c] && !write[c]) begin
                    data_out[c*DATA_W +: DATA_W] <= mem[bank_sel[c]][word_sel[c]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (gnt_vld[b] && write[gnt_idx[b]]) begin
                    mem[b][word_sel[gnt_idx[b]]] <= wdata[gnt_idx[b]];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shared_memory_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shared_memory_rr: scoreboard bench for shared_memory_rr.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_shared_memory_rr;
    localparam int NC = 16;
    localparam int NB = 16;
    localparam int DW = 8;
    localparam int AW = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NC-1:0]    read;
    logic [NC-1:0]    write;
    logic [NC*AW-1:0] addr_in;
    logic [NC*DW-1:0] data_in;
    logic [NC*DW-1:0] data_out;
    logic [NC-1:0]    finish;

    shared_memory_rr #(.N_CORES(NC), .N_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .read     (read),
        .write    (write),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .data_out (data_out),
        .finish   (finish)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            core;
        int            at_edge;
        logic [DW-1:0] data;
    } exp_t;

    exp_t scb[$];
    int   total    = 0;
    int   bad      = 0;
    int   edge_cnt = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Per-core request as the core currently presents it
    bit            rd_r [NC];
    bit            wr_r [NC];
    logic [AW-1:0] a_r  [NC];
    logic [DW-1:0] d_r  [NC];

    // Reference model state
    bit            mfin     [NC];
    int            mptr     [NB];
    logic [DW-1:0] ref_mem  [2**AW];
    logic [DW-1:0] ref_dout [NC];

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(posedge clock) begin
        int idx;
        #1;
        if (!reset) begin
            total = total + 2;
            if (finish !== '0) begin
                bad++;
                $display("FAIL reset_finish edge=%0d got=%h want=0", edge_cnt, finish);
            end
            if (data_out !== '0) begin
                bad++;
                $display("FAIL reset_data edge=%0d got=%h want=0", edge_cnt, data_out);
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                idx = -1;
                for (int j = 0; j < scb.size(); j++) begin
                    if (idx < 0 && scb[j].core == c && scb[j].at_edge == edge_cnt) idx = j;
                end
                if (idx >= 0) begin
                    total++;
                    if (finish[c] !== 1'b1) begin
                        bad++;
                        $display("FAIL missing_finish core=%0d edge=%0d got=%b want=1", c, edge_cnt, finish[c]);
                    end else if (data_out[c*DW +: DW] !== scb[idx].data) begin
                        bad++;
                        $display("FAIL data core=%0d edge=%0d got=%h want=%h",
                                 c, edge_cnt, data_out[c*DW +: DW], scb[idx].data);
                    end
                    scb.delete(idx);
                end else if (finish[c] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_finish core=%0d edge=%0d got=%b want=0", c, edge_cnt, finish[c]);
                end
            end
        end
    end

    // Round-robin per bank: the winner is the requester closest after the pointer.
    task automatic model_step();
        bit srv [NC];
        int best;
        int bd;
        int d;
        if (!reset) begin
            for (int c = 0; c < NC; c++) begin
                mfin[c]     = 1'b0;
                ref_dout[c] = '0;
            end
            for (int b = 0; b < NB; b++) mptr[b] = NC - 1;
            return;
        end
        for (int c = 0; c < NC; c++) srv[c] = 1'b0;
        for (int b = 0; b < NB; b++) begin
            best = -1;
            bd   = NC;
            for (int c = 0; c < NC; c++) begin
                if ((rd_r[c] || wr_r[c]) && !mfin[c] && (int'(a_r[c]) % NB == b)) begin
                    d = (c - mptr[b] - 1 + 2*NC) % NC;
                    if (d < bd) begin
                        bd   = d;
                        best = c;
                    end
                end
            end
            if (best >= 0) begin
                srv[best] = 1'b1;
                mptr[b]   = best;
`ifdef SHMEM_READ_BCAST_EN
                if (!wr_r[best]) begin
                    for (int c = 0; c < NC; c++) begin
                        if (c != best && rd_r[c] && !wr_r[c] && !mfin[c] && a_r[c] == a_r[best]) srv[c] = 1'b1;
                    end
                end
`endif
            end
        end
        for (int c = 0; c < NC; c++) if (srv[c] && !wr_r[c]) ref_dout[c] = ref_mem[a_r[c]];
        for (int c = 0; c < NC; c++) if (srv[c] && wr_r[c]) ref_mem[a_r[c]] = d_r[c];
        for (int c = 0; c < NC; c++) begin
            if (srv[c]) begin
                scb.push_back('{c, edge_cnt + 1, ref_dout[c]});
                rd_r[c] = 1'b0;
                wr_r[c] = 1'b0;
            end
            mfin[c] = srv[c];
        end
    endtask

    task automatic tick();
        for (int c = 0; c < NC; c++) begin
            read[c]              = rd_r[c];
            write[c]             = wr_r[c];
            addr_in[c*AW +: AW]  = a_r[c];
            data_in[c*DW +: DW]  = d_r[c];
        end
        model_step();
        @(posedge clock);
        #3;
    endtask

    task automatic issue(input int c, input bit r, input bit w, input int a, input int dat);
        rd_r[c] = r;
        wr_r[c] = w;
        a_r[c]  = AW'(a);
        d_r[c]  = DW'(dat);
    endtask

    task automatic drain();
        int n;
        bit busy;
        n = 0;
        do begin
            busy = 1'b0;
            for (int c = 0; c < NC; c++) if (rd_r[c] || wr_r[c]) busy = 1'b1;
            if (busy) begin
                tick();
                n++;
            end
        end while (busy && n < 200);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d_cycles want=<200", n);
            for (int c = 0; c < NC; c++) begin
                rd_r[c] = 1'b0;
                wr_r[c] = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        for (int c = 0; c < NC; c++) issue(c, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Give every RAM word a known value
        for (int w = 0; w < 2**AW / NB; w++) begin
            for (int c = 0; c < NC; c++) issue(c, 1'b0, 1'b1, w*NB + c, int'($urandom));
            drain();
        end

        // Parallel writes to distinct banks, then read back
        for (int c = 0; c < NC; c++) issue(c, 1'b0, 1'b1, c, 'hA0 + c);
        drain();
        for (int c = 0; c < NC; c++) issue(c, 1'b1, 1'b0, c, 0);
        drain();

        // Reset with everyone writing address 0; no write may land, core 0 first afterwards
        reset = 1'b0;
        for (int c = 0; c < NC; c++) issue(c, 1'b0, 1'b1, 0, 'hEE);
        tick();
        tick();
        tick();
        for (int c = 0; c < NC; c++) issue(c, 1'b1, 1'b0, 0, 0);
        reset = 1'b1;
        drain();

        // Three-way conflict on bank 5, twice
        for (int r = 0; r < 2; r++) begin
            issue(3,  1'b0, 1'b1, 'h015, int'($urandom));
            issue(7,  1'b0, 1'b1, 'h025, int'($urandom));
            issue(12, 1'b0, 1'b1, 'h035, int'($urandom));
            drain();
        end

        // Read versus write on the same word; read+write counts as a write
        issue(0, 1'b0, 1'b1, 'h0A3, 'h11);
        drain();
        issue(0, 1'b0, 1'b1, 'h0A3, 'h55);
        issue(1, 1'b1, 1'b0, 'h0A3, 0);
        issue(2, 1'b1, 1'b1, 'h0B7, 'h77);
        drain();
        issue(2, 1'b1, 1'b0, 'h0B7, 0);
        issue(3, 1'b1, 1'b0, 'h0A3, 0);
        drain();

        // Reset in the middle of a four-way conflict on bank 0
        for (int c = 1; c <= 4; c++) issue(c, 1'b0, 1'b1, c*16, 'h40 + c);
        drain();
        for (int c = 1; c <= 4; c++) issue(c, 1'b0, 1'b1, c*16, 'hC0 + c);
        tick();
        reset = 1'b0;
        for (int c = 0; c < NC; c++) issue(c, 1'b0, 1'b0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) issue(c, 1'b1, 1'b0, c*16, 0);
        drain();

        // Eight readers of one word
        issue(0, 1'b0, 1'b1, 'h100, 'h3C);
        drain();
        for (int c = 0; c < 8; c++) issue(c, 1'b1, 1'b0, 'h100, 0);
        drain();

        // Random traffic on a small address window to force conflicts and hazards
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < NC; c++) begin
                if (!rd_r[c] && !wr_r[c] && $urandom_range(1, 0) == 1) begin
                    mode = int'($urandom_range(2, 0));
                    issue(c, mode != 1, mode != 0,
                          int'($urandom_range(3, 0)) * NB + int'($urandom_range(3, 0)),
                          int'($urandom));
                end
            end
            tick();
        end
        drain();
        tick();
        tick();

        total++;
        if (scb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", scb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
